// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared state encoding and default widths for the timer controller
package timer_pkg;

  localparam int TIMER_W  = 16;
  localparam int TIMER_PW = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } timer_state_e;

endpackage

// File: rtl/timer_prescaler.sv
// rtl/timer_prescaler.sv - PW-bit prescaler, one-cycle step strobe every prescale+1 enabled cycles
module timer_prescaler
  import timer_pkg::*;
#(
  parameter int PW = TIMER_PW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          en,
  input  logic [PW-1:0] prescale,
  output logic          step
);

  logic [PW-1:0] cnt;

  // Strobe is decoded from the count register so it lines up with the count wrapping to zero.
  assign step = en && (cnt == prescale);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= step ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/timer_ctrl.sv
// rtl/timer_ctrl.sv - timer controller: config handshake, IDLE/RUN/DONE FSM, counter, tick and sticky irq; optional TIMER_CAPTURE_EN
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int W  = TIMER_W,
  parameter int PW = TIMER_PW
) (
  input  logic          clk,
  input  logic          reset,
`ifdef TIMER_CAPTURE_EN
  input  logic          capture,
  output logic [W-1:0]  cap_q,
`endif
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [W-1:0]  cfg_limit,
  input  logic [PW-1:0] cfg_prescale,
  input  logic          cfg_periodic,
  input  logic          start,
  input  logic          stop,
  output logic [W-1:0]  q,
  output logic          busy,
  output logic          tick,
  output logic          irq,
  input  logic          irq_clr
);

  timer_state_e  state, state_d;
  logic [W-1:0]  limit_r;
  logic [PW-1:0] prescale_r;
  logic          periodic_r;
  logic [W-1:0]  q_d;
  logic          cfg_accept;
  logic          pre_clear;
  logic          pre_en;
  logic          step;
  logic          hit;

  assign cfg_ready  = (state != RUN);
  assign busy       = (state == RUN);
  assign cfg_accept = cfg_valid && cfg_ready;

  timer_prescaler #(.PW(PW)) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .clear    (pre_clear),
    .en       (pre_en),
    .prescale (prescale_r),
    .step     (step)
  );

  always_comb begin
    state_d   = state;
    q_d       = q;
    pre_clear = 1'b0;
    pre_en    = 1'b0;
    hit       = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_d   = RUN;
          q_d       = '0;
          pre_clear = 1'b1;
        end
      end
      RUN: begin
        // Abort takes priority over any step falling in the same cycle, so no tick escapes.
        if (stop) begin
          state_d = IDLE;
        end else begin
          pre_en = 1'b1;
          if (step) begin
            if (q == limit_r) begin
              hit = 1'b1;
              if (periodic_r) begin
                q_d = '0;
              end else begin
                state_d = DONE;
              end
            end else begin
              q_d = q + 1'b1;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      q          <= '0;
      limit_r    <= '0;
      prescale_r <= '0;
      periodic_r <= 1'b0;
      tick       <= 1'b0;
      irq        <= 1'b0;
    end else begin
      state <= state_d;
      q     <= q_d;
      tick  <= hit;
      if (cfg_accept) begin
        limit_r    <= cfg_limit;
        prescale_r <= cfg_prescale;
        periodic_r <= cfg_periodic;
      end
      if (hit) begin
        irq <= 1'b1;
      end else if (irq_clr) begin
        irq <= 1'b0;
      end
    end
  end

`ifdef TIMER_CAPTURE_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cap_q <= '0;
    end else if (capture) begin
      cap_q <= q;
    end
  end
`endif

endmodule

// File: tb/tb_timer_ctrl.sv
// tb/tb_timer_ctrl.sv - directed self-checking bench for timer_ctrl
module tb_timer_ctrl;

  localparam int W  = 16;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [W-1:0]  cfg_limit;
  logic [PW-1:0] cfg_prescale;
  logic          cfg_periodic;
  logic          start;
  logic          stop;
  logic [W-1:0]  q;
  logic          busy;
  logic          tick;
  logic          irq;
  logic          irq_clr;
`ifdef TIMER_CAPTURE_EN
  logic          capture;
  logic [W-1:0]  cap_q;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  timer_ctrl #(.W(W), .PW(PW)) dut (
    .clk          (clk),
    .reset        (reset),
`ifdef TIMER_CAPTURE_EN
    .capture      (capture),
    .cap_q        (cap_q),
`endif
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_limit    (cfg_limit),
    .cfg_prescale (cfg_prescale),
    .cfg_periodic (cfg_periodic),
    .start        (start),
    .stop         (stop),
    .q            (q),
    .busy         (busy),
    .tick         (tick),
    .irq          (irq),
    .irq_clr      (irq_clr)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cfg_start(input logic [W-1:0] lim, input logic [PW-1:0] pre, input logic per);
    cfg_valid    = 1'b1;
    cfg_limit    = lim;
    cfg_prescale = pre;
    cfg_periodic = per;
    start        = 1'b1;
    cyc();
    cfg_valid = 1'b0;
    start     = 1'b0;
  endtask

  initial begin
    int qexp [8];
    reset        = 1'b1;
    cfg_valid    = 1'b0;
    cfg_limit    = '0;
    cfg_prescale = '0;
    cfg_periodic = 1'b0;
    start        = 1'b0;
    stop         = 1'b0;
    irq_clr      = 1'b0;
`ifdef TIMER_CAPTURE_EN
    capture      = 1'b0;
`endif
    repeat (3) cyc();
    chk("rst_q", q, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tick", tick, 0);
    chk("rst_irq", irq, 0);
    chk("rst_ready", cfg_ready, 1);
    reset = 1'b0;

    // One-shot, limit 5, prescale 0
    cfg_start(16'd5, 8'd0, 1'b0);
    chk("os_q0", q, 0);
    chk("os_busy", busy, 1);
    chk("os_ready_run", cfg_ready, 0);
    for (int k = 1; k <= 5; k++) begin
      cyc();
      chk("os_q", q, k);
      chk("os_tick_early", tick, 0);
    end
    cyc();
    chk("os_tick", tick, 1);
    chk("os_busy_done", busy, 0);
    chk("os_q_hold", q, 5);
    chk("os_irq", irq, 1);
    chk("os_ready_done", cfg_ready, 1);
    cyc();
    chk("os_tick_pulse", tick, 0);
    chk("os_q_hold2", q, 5);

    irq_clr = 1'b1;
    cyc();
    irq_clr = 1'b0;
    chk("irq_clr", irq, 0);

    // Periodic, limit 3, prescale 1: q after edges 1..8
    qexp = '{0, 1, 1, 2, 2, 3, 3, 0};
    cfg_start(16'd3, 8'd1, 1'b1);
    chk("per_q0", q, 0);
    for (int e = 1; e <= 8; e++) begin
      cyc();
      chk("per_q", q, qexp[e-1]);
      chk("per_tick", tick, (e == 8) ? 1 : 0);
    end
    chk("per_irq_set", irq, 1);
    irq_clr = 1'b1;
    cyc();
    irq_clr = 1'b0;
    chk("per_irq_clr", irq, 0);
    for (int e = 10; e <= 16; e++) begin
      cyc();
      chk("per_tick2", tick, (e == 16) ? 1 : 0);
      chk("per_irq2", irq, (e == 16) ? 1 : 0);
    end
    chk("per_q_wrap", q, 0);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    chk("per_stop_busy", busy, 0);

    // Periodic, limit 0, prescale 2
    cfg_start(16'd0, 8'd2, 1'b1);
    for (int e = 1; e <= 9; e++) begin
      cyc();
      chk("l0_q", q, 0);
      chk("l0_tick", tick, (e % 3 == 0) ? 1 : 0);
    end
    stop = 1'b1;
    cyc();
    stop = 1'b0;

    // Stop+start together in RUN; cfg during RUN ignored
    cfg_start(16'd10, 8'd0, 1'b0);
    cfg_valid    = 1'b1;
    cfg_limit    = 16'd1;
    cfg_prescale = 8'd0;
    cfg_periodic = 1'b1;
    chk("run_ready", cfg_ready, 0);
    cyc();
    chk("ign_q1", q, 1);
    cyc();
    cfg_valid = 1'b0;
    chk("ign_q2", q, 2);
    chk("ign_tick", tick, 0);
    chk("ign_busy", busy, 1);
    stop  = 1'b1;
    start = 1'b1;
    cyc();
    stop  = 1'b0;
    start = 1'b0;
    chk("ss_busy", busy, 0);
    chk("ss_q", q, 2);
    chk("ss_tick", tick, 0);
    cyc();
    chk("ss_q_frozen", q, 2);
    chk("ss_ready", cfg_ready, 1);

    // Capture while counting, then reset mid-run at q=7
    cfg_start(16'd20, 8'd0, 1'b0);
    for (int e = 1; e <= 4; e++) cyc();
    chk("mid_q4", q, 4);
`ifdef TIMER_CAPTURE_EN
    capture = 1'b1;
    cyc();
    capture = 1'b0;
    chk("cap_q", cap_q, 4);
    chk("cap_q_cont", q, 5);
    cyc();
    cyc();
`else
    repeat (3) cyc();
`endif
    chk("mid_q7", q, 7);
    chk("mid_irq", irq, 1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("mr_q", q, 0);
    chk("mr_busy", busy, 0);
    chk("mr_irq", irq, 0);
    chk("mr_tick", tick, 0);
    chk("mr_ready", cfg_ready, 1);
`ifdef TIMER_CAPTURE_EN
    chk("mr_cap_q", cap_q, 0);
`endif

    // Latched config was reset too: limit 0, prescale 0, one-shot
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("rc_busy", busy, 1);
    cyc();
    chk("rc_tick", tick, 1);
    chk("rc_done", busy, 0);
    chk("rc_q", q, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
